fptd_decision_unit: RTL and testbench

Per-section output stage of the fully parallel turbo decoder (FPTD), directly downstream of `Section_razor1`. Each cycle it takes the section's extrinsic LLR `be1_DFF`, its a-priori LLR `ba1_DFF` and its systematic LLR `ba2`, and forms a saturated a-posteriori LLR and a hard decision. It counts valid iterations and applies early termination when the decision is stable. Cycles flagged by Razor (`Error_current_be1`) are discarded and replayed, never committed.

---
 rtl/fptd_pkg.sv | 35 +++
 rtl/fptd_llr_sat_add.sv | 27 ++
 rtl/fptd_decision_unit.sv | 133 +++++++++++++
 tb/tb_fptd_decision_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fptd_pkg.sv
// Shared types and helpers for the FPTD per-section decision unit.
package fptd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fptd_dec_state_t;

    localparam int FPTD_MAX_ITER_DEF = 16;
    localparam int FPTD_ITER_W_DEF   = $clog2(FPTD_MAX_ITER_DEF + 1);

    function automatic int fptd_iter_w(input int maxIter);
        return $clog2(maxIter + 1);
    endfunction

    // Sign-extends an inW-bit value held in x, then clips it to the signed outW-bit range.
    function automatic logic signed [31:0] sat_clip(input logic signed [31:0] x,
                                                    input int inW,
                                                    input int outW);
        logic signed [31:0] ext;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        ext = (x <<< (32 - inW)) >>> (32 - inW);
        hi  = (32'sd1 <<< (outW - 1)) - 32'sd1;
        lo  = -(32'sd1 <<< (outW - 1));
        if (ext > hi) begin
            return hi;
        end else if (ext < lo) begin
            return lo;
        end
        return ext;
    endfunction

endpackage

// File: rtl/fptd_llr_sat_add.sv
// Combinational three-input LLR adder: sign-extend to M+2 bits, add, clip to M+1 bits.
module fptd_llr_sat_add
    import fptd_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 5
) (
    input  logic signed [M-1:0] a_i,
    input  logic signed [M-1:0] b_i,
    input  logic signed [N-1:0] c_i,
    output logic signed [M:0]   sum_o,
    output logic                neg_o
);

    logic signed [M+1:0] rawSum;
    logic signed [31:0]  clipped;

    always_comb begin
        rawSum  = {{2{a_i[M-1]}}, a_i}
                + {{2{b_i[M-1]}}, b_i}
                + {{(M+2-N){c_i[N-1]}}, c_i};
        clipped = sat_clip({{(30-M){rawSum[M+1]}}, rawSum}, M + 2, M + 1);
        sum_o   = (M+1)'(clipped);
        neg_o   = sum_o[M];
    end

endmodule

// File: rtl/fptd_decision_unit.sv
// FPTD per-section decision stage: a-posteriori LLR, hard decision, iteration count, early stop.
// Optional Razor error counter output enabled by defining FPTD_RAZOR_STATS_EN.
module fptd_decision_unit
    import fptd_pkg::*;
#(
    parameter  int N            = 4,
    parameter  int M            = 5,
    parameter  int MAX_ITER     = FPTD_MAX_ITER_DEF,
    parameter  int STABLE_ITERS = 3,
    localparam int ITER_W       = fptd_iter_w(MAX_ITER)
) (
    input  logic                Clock,
    input  logic                nReset,
    input  logic                Start,
    input  logic                Enable,
    input  logic signed [M-1:0] ba1_DFF,
    input  logic signed [N-1:0] ba2,
    input  logic signed [M-1:0] be1_DFF,
    input  logic                Error_current_be1,
    output logic signed [M:0]   apost_llr,
    output logic                b1,
    output logic [ITER_W-1:0]   iter_count,
    output logic                Busy,
    output logic                Done
`ifdef FPTD_RAZOR_STATS_EN
    ,
    output logic [15:0]         razor_err_count
`endif
);

    localparam int STAB_W = (STABLE_ITERS > 0) ? $clog2(STABLE_ITERS + 1) : 1;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_ITERS);

    fptd_dec_state_t   state_q, state_d;
    logic signed [M:0] apost_q, apost_d;
    logic              b1_q, b1_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [STAB_W-1:0] stable_q, stable_d;
    logic              prevValid_q, prevValid_d;

    logic signed [M:0] sumSat;
    logic              sumNeg;
    logic              commit;

    fptd_llr_sat_add #(.N(N), .M(M)) u_sat_add (
        .a_i   (ba1_DFF),
        .b_i   (be1_DFF),
        .c_i   (ba2),
        .sum_o (sumSat),
        .neg_o (sumNeg)
    );

    assign commit = (state_q == RUN) && !Start && Enable && !Error_current_be1;

    // Start wins over everything; Razor-flagged and disabled cycles fall through and hold.
    always_comb begin
        state_d     = state_q;
        apost_d     = apost_q;
        b1_d        = b1_q;
        iter_d      = iter_q;
        stable_d    = stable_q;
        prevValid_d = prevValid_q;
        if (Start) begin
            state_d     = RUN;
            apost_d     = '0;
            b1_d        = 1'b0;
            iter_d      = '0;
            stable_d    = '0;
            prevValid_d = 1'b0;
        end else if (commit) begin
            apost_d     = sumSat;
            b1_d        = sumNeg;
            iter_d      = iter_q + 1'b1;
            prevValid_d = 1'b1;
            if (prevValid_q && (sumNeg == b1_q)) begin
                stable_d = (stable_q == STAB_MAX) ? stable_q : stable_q + 1'b1;
            end else begin
                stable_d = '0;
            end
            if ((iter_d == ITER_W'(MAX_ITER)) || ((STABLE_ITERS > 0) && (stable_d == STAB_MAX))) begin
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            apost_q     <= '0;
            b1_q        <= 1'b0;
            iter_q      <= '0;
            stable_q    <= '0;
            prevValid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            apost_q     <= apost_d;
            b1_q        <= b1_d;
            iter_q      <= iter_d;
            stable_q    <= stable_d;
            prevValid_q <= prevValid_d;
        end
    end

    assign apost_llr  = apost_q;
    assign b1         = b1_q;
    assign iter_count = iter_q;
    assign Busy       = (state_q == RUN);
    assign Done       = (state_q == DONE);

`ifdef FPTD_RAZOR_STATS_EN
    logic [15:0] razorCnt_q, razorCnt_d;

    always_comb begin
        razorCnt_d = razorCnt_q;
        if (Start) begin
            razorCnt_d = '0;
        end else if ((state_q == RUN) && Enable && Error_current_be1 && (razorCnt_q != 16'hFFFF)) begin
            razorCnt_d = razorCnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            razorCnt_q <= '0;
        end else begin
            razorCnt_q <= razorCnt_d;
        end
    end

    assign razor_err_count = razorCnt_q;
`endif

endmodule

// File: tb/tb_fptd_decision_unit.sv
// Self-checking bench for fptd_decision_unit: vector table plus multi-cycle sequences via a scoreboard.
// Razor counter checks are included when FPTD_RAZOR_STATS_EN is defined.
module tb_fptd_decision_unit;

    localparam int N            = 4;
    localparam int M            = 5;
    localparam int MAX_ITER     = 16;
    localparam int STABLE_ITERS = 3;

    logic                Clock;
    logic                nReset;
    logic                Start;
    logic                Enable;
    logic                Error_current_be1;
    logic signed [M-1:0] ba1_DFF;
    logic signed [N-1:0] ba2;
    logic signed [M-1:0] be1_DFF;
    logic signed [M:0]   apost_llr;
    logic                b1;
    logic [4:0]          iter_count;
    logic                Busy;
    logic                Done;
`ifdef FPTD_RAZOR_STATS_EN
    logic [15:0]         razor_err_count;
`endif

    fptd_decision_unit #(
        .N(N), .M(M), .MAX_ITER(MAX_ITER), .STABLE_ITERS(STABLE_ITERS)
    ) dut (
        .Clock             (Clock),
        .nReset            (nReset),
        .Start             (Start),
        .Enable            (Enable),
        .ba1_DFF           (ba1_DFF),
        .ba2               (ba2),
        .be1_DFF           (be1_DFF),
        .Error_current_be1 (Error_current_be1),
        .apost_llr         (apost_llr),
        .b1                (b1),
        .iter_count        (iter_count),
        .Busy              (Busy),
        .Done              (Done)
`ifdef FPTD_RAZOR_STATS_EN
        ,
        .razor_err_count   (razor_err_count)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        string name;
        int    apost;
        logic  b1;
        int    iter;
        logic  busy;
        logic  done;
    } exp_t;

    typedef struct {
        int   ba1;
        int   ba2;
        int   be1;
        int   apost;
        logic b1;
    } vec_t;

    exp_t sbQ[$];
    vec_t vecs[9];
    int   compareCount = 0;
    int   mismatchCount = 0;

    function automatic exp_t mkExp(input string nm, input int ap, input logic bb,
                                   input int it, input logic bz, input logic dn);
        exp_t e;
        e.name  = nm;
        e.apost = ap;
        e.b1    = bb;
        e.iter  = it;
        e.busy  = bz;
        e.done  = dn;
        return e;
    endfunction

    task automatic cmpField(input string nm, input string field, input integer act, input integer req);
        compareCount++;
        if (act !== req) begin
            mismatchCount++;
            $display("[TB] FAIL %s.%s: got %0d, want %0d", nm, field, act, req);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbQ.size() == 0) begin
            compareCount++;
            mismatchCount++;
            $display("[TB] FAIL scoreboard: no expected entry, got apost=%0d", apost_llr);
        end else begin
            e = sbQ.pop_front();
            cmpField(e.name, "apost_llr", apost_llr, e.apost);
            cmpField(e.name, "b1", b1, e.b1);
            cmpField(e.name, "iter_count", iter_count, e.iter);
            cmpField(e.name, "Busy", Busy, e.busy);
            cmpField(e.name, "Done", Done, e.done);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic en, input logic err,
                                 input int a1, input int a2, input int e1, input exp_t e);
        Start             = st;
        Enable            = en;
        Error_current_be1 = err;
        ba1_DFF           = M'(a1);
        ba2               = N'(a2);
        be1_DFF           = M'(e1);
        sbQ.push_back(e);
        @(posedge Clock);
        #1;
        checkOutput();
    endtask

    task automatic startFrame(input string nm);
        applyStimulus(1'b1, 1'b1, 1'b0, 7, 3, 9, mkExp(nm, 0, 1'b0, 0, 1'b1, 1'b0));
    endtask

    task automatic checkRazor(input string nm, input int req);
`ifdef FPTD_RAZOR_STATS_EN
        cmpField(nm, "razor_err_count", razor_err_count, req);
`endif
    endtask

    initial begin
        vecs[0] = '{ba1: -10, ba2:  2, be1:  -4, apost: -12, b1: 1'b1};
        vecs[1] = '{ba1: -16, ba2: -8, be1: -16, apost: -32, b1: 1'b1};
        vecs[2] = '{ba1:  15, ba2:  7, be1:  15, apost:  31, b1: 1'b0};
        vecs[3] = '{ba1:   0, ba2:  0, be1:   0, apost:   0, b1: 1'b0};
        vecs[4] = '{ba1:  15, ba2: -8, be1:  -7, apost:   0, b1: 1'b0};
        vecs[5] = '{ba1:  -1, ba2:  0, be1:   0, apost:  -1, b1: 1'b1};
        vecs[6] = '{ba1:  15, ba2:  7, be1:   9, apost:  31, b1: 1'b0};
        vecs[7] = '{ba1: -16, ba2: -8, be1:  -8, apost: -32, b1: 1'b1};
        vecs[8] = '{ba1:  12, ba2: -3, be1:   6, apost:  15, b1: 1'b0};

        nReset = 1'b1;
        Start = 1'b0;
        Enable = 1'b0;
        Error_current_be1 = 1'b0;
        ba1_DFF = '0;
        ba2 = '0;
        be1_DFF = '0;
        #1 nReset = 1'b0;
        #2;
        sbQ.push_back(mkExp("reset", 0, 1'b0, 0, 1'b0, 1'b0));
        checkOutput();
        checkRazor("reset", 0);
        @(posedge Clock);
        #3 nReset = 1'b1;
        @(posedge Clock);
        #1;

        applyStimulus(1'b0, 1'b1, 1'b0, -10, 2, -4, mkExp("idle_ignore", 0, 1'b0, 0, 1'b0, 1'b0));

        foreach (vecs[i]) begin
            startFrame($sformatf("vec%0d_start", i));
            applyStimulus(1'b0, 1'b1, 1'b0, vecs[i].ba1, vecs[i].ba2, vecs[i].be1,
                          mkExp($sformatf("vec%0d", i), vecs[i].apost, vecs[i].b1, 1, 1'b1, 1'b0));
        end

        startFrame("et_start");
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, -10, 2, -4,
                          mkExp($sformatf("et_commit%0d", k), -12, 1'b1, k, k != 4, k == 4));
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 15, 7, 15, mkExp("et_frozen", -12, 1'b1, 4, 1'b0, 1'b1));
        end

        startFrame("razor_start");
        checkRazor("razor_start", 0);
        applyStimulus(1'b0, 1'b1, 1'b0, -10, 2, -4, mkExp("razor_clean1", -12, 1'b1, 1, 1'b1, 1'b0));
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, -10, 2, 15, mkExp("razor_err", -12, 1'b1, 1, 1'b1, 1'b0));
        end
        checkRazor("razor_after_err", 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 15, 7, 15, mkExp("razor_disabled", -12, 1'b1, 1, 1'b1, 1'b0));
        applyStimulus(1'b0, 1'b1, 1'b0, 15, 7, 15, mkExp("razor_replay", 31, 1'b0, 2, 1'b1, 1'b0));
        checkRazor("razor_after_clean", 3);

        startFrame("maxit_start");
        checkRazor("maxit_start", 0);
        for (int i = 0; i < MAX_ITER; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, (i % 2 == 0) ? -5 : 5,
                          mkExp($sformatf("maxit%0d", i + 1), (i % 2 == 0) ? -5 : 5, i % 2 == 0,
                                i + 1, i != MAX_ITER - 1, i == MAX_ITER - 1));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, -16, -8, -16, mkExp("maxit_frozen", 5, 1'b0, 16, 1'b0, 1'b1));

        startFrame("abort_start");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, (i % 2 == 0) ? -5 : 5,
                          mkExp($sformatf("abort_commit%0d", i + 1), (i % 2 == 0) ? -5 : 5, i % 2 == 0,
                                i + 1, 1'b1, 1'b0));
        end
        applyStimulus(1'b1, 1'b1, 1'b0, -10, 2, -4, mkExp("abort_restart", 0, 1'b0, 0, 1'b1, 1'b0));
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, -10, 2, -4,
                          mkExp($sformatf("restart_commit%0d", k), -12, 1'b1, k, k != 4, k == 4));
        end

        startFrame("rst_start");
        applyStimulus(1'b0, 1'b1, 1'b0, -10, 2, -4, mkExp("rst_commit", -12, 1'b1, 1, 1'b1, 1'b0));
        applyStimulus(1'b0, 1'b1, 1'b1, -10, 2, 15, mkExp("rst_err", -12, 1'b1, 1, 1'b1, 1'b0));
        #2 nReset = 1'b0;
        #1;
        sbQ.push_back(mkExp("async_reset", 0, 1'b0, 0, 1'b0, 1'b0));
        checkOutput();
        checkRazor("async_reset", 0);
        #2 nReset = 1'b1;
        @(posedge Clock);
        #1;
        applyStimulus(1'b0, 1'b1, 1'b0, -10, 2, -4, mkExp("post_reset_idle", 0, 1'b0, 0, 1'b0, 1'b0));

        if (sbQ.size() != 0) begin
            compareCount++;
            mismatchCount++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", sbQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
